// File: rtl/codificador_tx.sv
// codificador_tx: SECDED (8,4) encoder feeding a UART-style serial transmitter.
// Frame = start bit (0), 8 codeword bits LSB first, stop bit (1), each held
// CLKS_PER_BIT clocks. Optional macro ERROR_INJECT_EN adds the err_inj port,
// whose mask is XORed into the codeword when a frame is accepted.
module codificador_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] entrada,
`ifdef ERROR_INJECT_EN
  input  logic [7:0] err_inj,
`endif
  output logic       tx_serial,
  output logic       busy,
  output logic       done,
  output logic [7:0] palabra_tx
);

  localparam int              CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic          r_tx;
  logic [7:0]    r_word;

  logic [7:0]    w_code;
  logic [7:0]    w_frame_word;
  logic          w_bit_end;
  logic [2:0]    w_next_bit;

  // SECDED (8,4) encoder: Hamming parity at positions 1,2,4, overall parity at 0
  always_comb begin
    w_code    = '0;
    w_code[3] = entrada[0];
    w_code[5] = entrada[1];
    w_code[6] = entrada[2];
    w_code[7] = entrada[3];
    w_code[1] = entrada[0] ^ entrada[1] ^ entrada[3];
    w_code[2] = entrada[0] ^ entrada[2] ^ entrada[3];
    w_code[4] = entrada[1] ^ entrada[2] ^ entrada[3];
    w_code[0] = ^w_code[7:1];
  end

`ifdef ERROR_INJECT_EN
  assign w_frame_word = w_code ^ err_inj;
`else
  assign w_frame_word = w_code;
`endif

  assign w_bit_end  = (r_baud == BAUD_LAST);
  assign w_next_bit = r_bit + 3'd1;

  // Frame sequencer: state, baud counter, bit index, registered line and codeword
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_word  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          r_tx   <= 1'b1;
          if (start) begin
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_word  <= w_frame_word;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_word[0];
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_bit   <= '0;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= w_next_bit;
              r_tx  <= r_word[w_next_bit];
            end
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_bit   <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_serial  = r_tx;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_STOP) && w_bit_end;
  assign palabra_tx = r_word;

endmodule
